// File: rtl/ray_aabb_pkg.sv
// rtl/ray_aabb_pkg.sv - FloPoCo 11_10 field constants, FSM encoding and rank helper for the slab resolver
package ray_aabb_pkg;

  localparam int FP_W     = 24;
  localparam int EXC_HI   = 23;
  localparam int EXC_LO   = 22;
  localparam int SIGN_BIT = 21;
  localparam int MAG_HI   = 20;
  localparam int MAG_LO   = 0;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  localparam logic [FP_W-1:0] FP_POS_ZERO = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEAR_Y,
    ST_NEAR_Z,
    ST_FAR_Y,
    ST_FAR_Z,
    ST_ORDER,
    ST_SIGN,
    ST_DONE
  } state_e;

  // Coarse position on the number line: -inf, -normal, zero, +normal, +inf.
  function automatic logic [2:0] fp_rank(input logic [FP_W-1:0] v);
    logic [2:0] r;
    case (v[EXC_HI:EXC_LO])
      EXC_NORMAL: r = v[SIGN_BIT] ? 3'd1 : 3'd3;
      EXC_INF:    r = v[SIGN_BIT] ? 3'd0 : 3'd4;
      default:    r = 3'd2;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_lt_11_10.sv
// rtl/fp_lt_11_10.sv - combinational total-order less-than on FloPoCo 11_10 words, NaN compares false
module fp_lt_11_10
  import ray_aabb_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic            lt_o
);

  logic [2:0] rank_a;
  logic [2:0] rank_b;
  logic       any_nan;

  assign rank_a  = fp_rank(a_i);
  assign rank_b  = fp_rank(b_i);
  assign any_nan = (a_i[EXC_HI:EXC_LO] == EXC_NAN) || (b_i[EXC_HI:EXC_LO] == EXC_NAN);

  always_comb begin
    lt_o = 1'b0;
    if (any_nan) begin
      lt_o = 1'b0;
    end else if (rank_a != rank_b) begin
      lt_o = rank_a < rank_b;
    end else if (rank_a == 3'd3) begin
      lt_o = a_i[MAG_HI:MAG_LO] < b_i[MAG_HI:MAG_LO];
    end else if (rank_a == 3'd1) begin
      // Negative normals: larger magnitude is the smaller value.
      lt_o = a_i[MAG_HI:MAG_LO] > b_i[MAG_HI:MAG_LO];
    end
  end

endmodule

// File: rtl/ray_aabb_slab_resolve.sv
// rtl/ray_aabb_slab_resolve.sv - serial max(t_near)/min(t_far) reduction and hit decision on one shared comparator
module ray_aabb_slab_resolve
  import ray_aabb_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int WE    = 11,
  parameter int WF    = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] tnear_x,
  input  logic [WIDTH:0] tnear_y,
  input  logic [WIDTH:0] tnear_z,
  input  logic [WIDTH:0] tfar_x,
  input  logic [WIDTH:0] tfar_y,
  input  logic [WIDTH:0] tfar_z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           hit,
  output logic [WIDTH:0] t_entry,
  output logic [WIDTH:0] t_exit
);

  if (WIDTH != 23 || WE != 11 || WF != 10) begin : g_bad_cfg
    $error("ray_aabb_slab_resolve supports only the 11_10 format");
  end

  state_e state_q, state_d;
  logic [WIDTH:0] entry_q, entry_d, exit_q, exit_d;
  logic [WIDTH:0] near_y_q, near_y_d, near_z_q, near_z_d;
  logic [WIDTH:0] far_y_q, far_y_d, far_z_q, far_z_d;
  logic [WIDTH:0] t_entry_q, t_entry_d, t_exit_q, t_exit_d;
  logic nan_q, nan_d, miss_o_q, miss_o_d, miss_s_q, miss_s_d;
  logic out_valid_q, out_valid_d, hit_q, hit_d;
  logic [WIDTH:0] cmp_a, cmp_b;
  logic cmp_lt;

  fp_lt_11_10 u_lt (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .lt_o (cmp_lt)
  );

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    exit_d      = exit_q;
    near_y_d    = near_y_q;
    near_z_d    = near_z_q;
    far_y_d     = far_y_q;
    far_z_d     = far_z_q;
    nan_d       = nan_q;
    miss_o_d    = miss_o_q;
    miss_s_d    = miss_s_q;
    out_valid_d = out_valid_q;
    hit_d       = hit_q;
    t_entry_d   = t_entry_q;
    t_exit_d    = t_exit_q;
    cmp_a       = FP_POS_ZERO;
    cmp_b       = FP_POS_ZERO;
    in_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          entry_d  = tnear_x;
          exit_d   = tfar_x;
          near_y_d = tnear_y;
          near_z_d = tnear_z;
          far_y_d  = tfar_y;
          far_z_d  = tfar_z;
          nan_d    = (tnear_x[EXC_HI:EXC_LO] == EXC_NAN) || (tnear_y[EXC_HI:EXC_LO] == EXC_NAN)
                  || (tnear_z[EXC_HI:EXC_LO] == EXC_NAN) || (tfar_x[EXC_HI:EXC_LO] == EXC_NAN)
                  || (tfar_y[EXC_HI:EXC_LO] == EXC_NAN) || (tfar_z[EXC_HI:EXC_LO] == EXC_NAN);
          state_d  = ST_NEAR_Y;
        end
      end
      ST_NEAR_Y: begin
        cmp_a = entry_q;
        cmp_b = near_y_q;
        if (cmp_lt) entry_d = near_y_q;
        state_d = ST_NEAR_Z;
      end
      ST_NEAR_Z: begin
        cmp_a = entry_q;
        cmp_b = near_z_q;
        if (cmp_lt) entry_d = near_z_q;
        state_d = ST_FAR_Y;
      end
      ST_FAR_Y: begin
        cmp_a = far_y_q;
        cmp_b = exit_q;
        if (cmp_lt) exit_d = far_y_q;
        state_d = ST_FAR_Z;
      end
      ST_FAR_Z: begin
        cmp_a = far_z_q;
        cmp_b = exit_q;
        if (cmp_lt) exit_d = far_z_q;
        state_d = ST_ORDER;
      end
      ST_ORDER: begin
        cmp_a    = exit_q;
        cmp_b    = entry_q;
        miss_o_d = cmp_lt;
        state_d  = ST_SIGN;
      end
      ST_SIGN: begin
        cmp_a       = exit_q;
        cmp_b       = FP_POS_ZERO;
        miss_s_d    = cmp_lt;
        out_valid_d = 1'b1;
        hit_d       = !(nan_q || miss_o_q || cmp_lt);
        t_entry_d   = entry_q;
        t_exit_d    = exit_q;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      entry_q     <= '0;
      exit_q      <= '0;
      near_y_q    <= '0;
      near_z_q    <= '0;
      far_y_q     <= '0;
      far_z_q     <= '0;
      nan_q       <= 1'b0;
      miss_o_q    <= 1'b0;
      miss_s_q    <= 1'b0;
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      t_entry_q   <= '0;
      t_exit_q    <= '0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      exit_q      <= exit_d;
      near_y_q    <= near_y_d;
      near_z_q    <= near_z_d;
      far_y_q     <= far_y_d;
      far_z_q     <= far_z_d;
      nan_q       <= nan_d;
      miss_o_q    <= miss_o_d;
      miss_s_q    <= miss_s_d;
      out_valid_q <= out_valid_d;
      hit_q       <= hit_d;
      t_entry_q   <= t_entry_d;
      t_exit_q    <= t_exit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign hit       = hit_q;
  assign t_entry   = t_entry_q;
  assign t_exit    = t_exit_q;

endmodule
